floo_sa_local_lock: RTL and testbench

Local switch-allocation stage for one input port of the virtual-channel router. Each cycle it selects one requesting VC by round-robin arbitration and presents that VC's output direction as a one-hot request to global switch allocation. On top of the plain per-flit arbiter, it adds two features:
- an output-readiness pre-filter;
- an optional wormhole lock that keeps one VC and its direction granted from head flit to tail flit.

---
 rtl/floo_sa_local_lock_if.sv | 40 ++++
 rtl/floo_sa_local_lock.sv | 147 ++++++++++++++
 tb/tb_floo_sa_local_lock.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/floo_sa_local_lock_if.sv
// Interface bundling the local switch-allocation request/grant signals of one
// router input port.
//   vc_head_v / vc_head_dir / vc_head_last : per-VC head flit valid, lookahead
//                                            output direction and tail marker
//   out_ready                              : per-output-port readiness
//   sa_global_grant                        : global SA accepted the request
//   sa_local_v / sa_local_vc_id(_oh)       : presented request and chosen VC
//   sa_local_output_dir_oh                 : requested output port, one-hot
//   locked                                 : wormhole lock is held
// The master modport drives the per-VC heads, the readiness and the grant.
// The slave modport is the allocator itself.
interface floo_sa_local_lock_if #(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned NumPorts   = 5,
    parameter int unsigned DirWidth   = $clog2(NumPorts)
);
    logic [NumVC-1:0]                vc_head_v;
    logic [NumVC-1:0][DirWidth-1:0]  vc_head_dir;
    logic [NumVC-1:0]                vc_head_last;
    logic [NumPorts-1:0]             out_ready;
    logic                            sa_global_grant;
    logic                            sa_local_v;
    logic [NumVCWidth-1:0]           sa_local_vc_id;
    logic [NumVC-1:0]                sa_local_vc_id_oh;
    logic [NumPorts-1:0]             sa_local_output_dir_oh;
    logic                            locked;

    modport master (
        output vc_head_v, vc_head_dir, vc_head_last, out_ready, sa_global_grant,
        input  sa_local_v, sa_local_vc_id, sa_local_vc_id_oh,
               sa_local_output_dir_oh, locked
    );

    modport slave (
        input  vc_head_v, vc_head_dir, vc_head_last, out_ready, sa_global_grant,
        output sa_local_v, sa_local_vc_id, sa_local_vc_id_oh,
               sa_local_output_dir_oh, locked
    );
endinterface

// File: rtl/floo_sa_local_lock.sv
// Local switch allocation for one router input port. Each cycle it picks one
// eligible VC by round-robin and presents that VC's output direction to
// global SA. An optional wormhole lock holds the VC and direction from the
// head flit to the tail flit. An optional readiness filter drops VCs whose
// output port cannot accept a flit.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   sa    : floo_sa_local_lock_if.slave (heads, readiness, grant in; request,
//           chosen VC, direction one-hot and lock status out)
// The request path is purely combinational (0-cycle latency). The lock state
// and the round-robin pointer update on the edge after an accepted transfer.
module floo_sa_local_lock #(
    parameter int unsigned NumVC        = 4,
    parameter int unsigned NumVCWidth   = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned NumPorts     = 5,
    parameter int unsigned DirWidth     = $clog2(NumPorts),
    parameter int unsigned WormholeLock = 1,
    parameter int unsigned MaskNotReady = 1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    floo_sa_local_lock_if.slave sa
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [NumVCWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [NumVCWidth-1:0] lock_vc_q, lock_vc_d;
    logic [DirWidth-1:0]   lock_dir_q, lock_dir_d;

    logic [NumVC-1:0]      eligible;
    logic                  found;
    logic [NumVCWidth-1:0] winner;
    logic                  req_v;
    logic [NumVCWidth-1:0] req_vc;
    logic [DirWidth-1:0]   req_dir;

    // Modular increment. With a single VC this always yields 0.
    function automatic logic [NumVCWidth-1:0] vc_inc(input logic [NumVCWidth-1:0] v);
        return NumVCWidth'((32'(v) + 32'd1) % NumVC);
    endfunction

    // An out-of-range direction is never eligible, and out_ready is never
    // indexed with it.
    always_comb begin
        eligible = '0;
        for (int v = 0; v < NumVC; v++) begin
            if (sa.vc_head_v[v] && (32'(sa.vc_head_dir[v]) < NumPorts)) begin
                eligible[v] = (MaskNotReady == 0) || sa.out_ready[sa.vc_head_dir[v]];
            end
        end
    end

    // Round-robin scan starting at rr_ptr. winner stays 0 when nothing is
    // eligible, so the IDLE outputs fall to zero without a separate mux.
    always_comb begin
        logic [NumVCWidth-1:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NumVC; i++) begin
            idx = NumVCWidth'((32'(rr_ptr_q) + 32'(i)) % NumVC);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_vc_d  = lock_vc_q;
        lock_dir_d = lock_dir_q;
        req_v      = 1'b0;
        req_vc     = '0;
        req_dir    = '0;
        case (state_q)
            IDLE: begin
                req_v   = found;
                req_vc  = winner;
                req_dir = sa.vc_head_dir[winner];
                if (sa.sa_global_grant && found) begin
                    if (sa.vc_head_last[winner] || (WormholeLock == 0)) begin
                        rr_ptr_d = vc_inc(winner);
                    end else begin
                        // The pointer stays put while locked. It advances
                        // past lock_vc when the tail leaves.
                        state_d    = LOCKED;
                        lock_vc_d  = winner;
                        lock_dir_d = sa.vc_head_dir[winner];
                    end
                end
            end
            LOCKED: begin
                // Body flits carry no valid direction. The one latched from
                // the head is used.
                req_v   = sa.vc_head_v[lock_vc_q] &&
                          ((MaskNotReady == 0) || sa.out_ready[lock_dir_q]);
                req_vc  = lock_vc_q;
                req_dir = lock_dir_q;
                if (sa.sa_global_grant && req_v && sa.vc_head_last[lock_vc_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = vc_inc(lock_vc_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_vc_q  <= '0;
            lock_dir_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_vc_q  <= lock_vc_d;
            lock_dir_q <= lock_dir_d;
        end
    end

    assign sa.sa_local_v             = req_v;
    assign sa.sa_local_vc_id         = req_vc;
    // While locked, the VC stays visible even when the request is held back.
    assign sa.sa_local_vc_id_oh      = (req_v || (state_q == LOCKED)) ?
                                       (NumVC'(1) << req_vc) : '0;
    assign sa.sa_local_output_dir_oh = req_v ? (NumPorts'(1) << req_dir) : '0;
    assign sa.locked                 = (state_q == LOCKED);

    // Upstream must never present a valid head with a direction outside the
    // router.
    for (genvar v = 0; v < NumVC; v++) begin : g_dir_chk
        a_dir_range: assert property (@(posedge clk_i) disable iff (rst_i)
            sa.vc_head_v[v] |-> (32'(sa.vc_head_dir[v]) < NumPorts));
    end

    // A grant without a request is dropped by the logic above, but it points
    // to a global SA bug.
    a_grant_no_req: assert property (@(posedge clk_i) disable iff (rst_i)
        sa.sa_global_grant |-> sa.sa_local_v);

endmodule

// File: tb/tb_floo_sa_local_lock.sv
module tb_floo_sa_local_lock;

    logic clk = 1'b0;
    logic rst;
    logic grant_nw;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    floo_sa_local_lock_if #(.NumVC(4), .NumPorts(5)) bus ();
    floo_sa_local_lock_if #(.NumVC(4), .NumPorts(5)) bus_nw ();

    // The non-locking instance sees the same heads and readiness as the main
    // one. It has its own grant.
    assign bus_nw.vc_head_v       = bus.vc_head_v;
    assign bus_nw.vc_head_dir     = bus.vc_head_dir;
    assign bus_nw.vc_head_last    = bus.vc_head_last;
    assign bus_nw.out_ready       = bus.out_ready;
    assign bus_nw.sa_global_grant = grant_nw;

    floo_sa_local_lock #(.NumVC(4), .NumPorts(5), .WormholeLock(1), .MaskNotReady(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sa    (bus.slave)
    );

    floo_sa_local_lock #(.NumVC(4), .NumPorts(5), .WormholeLock(0), .MaskNotReady(1)) dut_nw (
        .clk_i (clk),
        .rst_i (rst),
        .sa    (bus_nw.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vc(input int v, input logic valid, input int dir, input logic last);
        bus.vc_head_v[v]    = valid;
        bus.vc_head_dir[v]  = 3'(dir);
        bus.vc_head_last[v] = last;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic cmp_req(input string tag,
                           input logic obs_v, input logic [1:0] obs_id, input logic [3:0] obs_oh,
                           input logic [4:0] obs_dir, input logic obs_lock,
                           input logic ev, input int evc, input int edir, input logic elock);
        logic [3:0] exp_oh;
        logic [4:0] exp_dir;
        exp_oh  = (ev || elock) ? (4'd1 << evc) : 4'd0;
        exp_dir = ev ? (5'd1 << edir) : 5'd0;
        chk({tag, ".v"},    32'(obs_v),    32'(ev));
        chk({tag, ".vc"},   32'(obs_id),   (ev || elock) ? 32'(evc) : 32'd0);
        chk({tag, ".vcoh"}, 32'(obs_oh),   32'(exp_oh));
        chk({tag, ".dir"},  32'(obs_dir),  32'(exp_dir));
        chk({tag, ".lock"}, 32'(obs_lock), 32'(elock));
    endtask

    task automatic em(input string tag, input logic ev, input int evc, input int edir, input logic elock);
        cmp_req(tag, bus.sa_local_v, bus.sa_local_vc_id, bus.sa_local_vc_id_oh,
                bus.sa_local_output_dir_oh, bus.locked, ev, evc, edir, elock);
    endtask

    task automatic en(input string tag, input logic ev, input int evc, input int edir, input logic elock);
        cmp_req(tag, bus_nw.sa_local_v, bus_nw.sa_local_vc_id, bus_nw.sa_local_vc_id_oh,
                bus_nw.sa_local_output_dir_oh, bus_nw.locked, ev, evc, edir, elock);
    endtask

    task automatic clear_vcs;
        for (int v = 0; v < 4; v++) set_vc(v, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst                 = 1'b1;
        clear_vcs();
        bus.out_ready       = 5'b11111;
        bus.sa_global_grant = 1'b0;
        grant_nw            = 1'b0;

        // Reset state with no heads valid.
        step(); step(); settle();
        em("rst", 1'b0, 0, 0, 1'b0);
        en("rst_nw", 1'b0, 0, 0, 1'b0);
        rst = 1'b0;

        // Round-robin fairness over single-flit packets.
        for (int v = 0; v < 4; v++) set_vc(v, 1'b1, v, 1'b1);
        bus.sa_global_grant = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            em($sformatf("rr%0d", k), 1'b1, k % 4, k % 4, 1'b0);
            step();
        end

        // Wormhole lock. VC1 alone first moves the pointer to 2.
        clear_vcs();
        set_vc(1, 1'b1, 1, 1'b1);
        settle(); em("wl_pre", 1'b1, 1, 1, 1'b0); step();
        set_vc(2, 1'b1, 4, 1'b0);
        settle(); em("wl_head", 1'b1, 2, 4, 1'b0); step();
        set_vc(2, 1'b1, 0, 1'b0);
        settle(); em("wl_body", 1'b1, 2, 4, 1'b1); step();
        set_vc(2, 1'b1, 0, 1'b1);
        settle(); em("wl_tail", 1'b1, 2, 4, 1'b1); step();
        set_vc(2, 1'b0, 0, 1'b0);
        settle(); em("wl_next", 1'b1, 1, 1, 1'b0); step();

        // Ready masking. VC3 alone first brings the pointer back to 0.
        set_vc(1, 1'b0, 0, 1'b0);
        set_vc(3, 1'b1, 2, 1'b1);
        settle(); em("rm_pre", 1'b1, 3, 2, 1'b0); step();
        set_vc(0, 1'b1, 1, 1'b1);
        set_vc(3, 1'b1, 2, 1'b0);
        bus.out_ready = 5'b11101;
        settle(); em("rm_mask", 1'b1, 3, 2, 1'b0); step();
        bus.sa_global_grant = 1'b0;
        set_vc(3, 1'b1, 0, 1'b0);
        bus.out_ready = 5'b11011;
        settle(); em("rm_drop", 1'b0, 3, 0, 1'b1); step();
        settle(); em("rm_hold", 1'b0, 3, 0, 1'b1);
        bus.out_ready = 5'b11111;
        settle(); em("rm_back", 1'b1, 3, 2, 1'b1);

        // Reset mid-packet while locked on VC3.
        rst = 1'b1;
        step(); settle();
        em("rst_mid", 1'b1, 0, 1, 1'b0);
        rst = 1'b0;
        set_vc(0, 1'b0, 0, 1'b0);
        set_vc(1, 1'b1, 3, 1'b1);
        step(); settle();
        em("rst_after", 1'b1, 1, 3, 1'b0);

        // Grant withheld: VC1 keeps priority, then the pointer moves to 2.
        set_vc(3, 1'b0, 0, 1'b0);
        set_vc(1, 1'b1, 1, 1'b1);
        set_vc(2, 1'b1, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle(); em($sformatf("gw_hold%0d", k), 1'b1, 1, 1, 1'b0); step();
        end
        bus.sa_global_grant = 1'b1;
        settle(); em("gw_grant", 1'b1, 1, 1, 1'b0); step();
        bus.sa_global_grant = 1'b0;
        settle(); em("gw_after", 1'b1, 2, 2, 1'b0);

        // Scenario 2 again without the lock. VC2 and VC1 alternate per flit.
        clear_vcs();
        set_vc(1, 1'b1, 1, 1'b1);
        grant_nw = 1'b1;
        settle(); en("nw_pre", 1'b1, 1, 1, 1'b0); step();
        set_vc(2, 1'b1, 4, 1'b0);
        settle(); en("nw_a", 1'b1, 2, 4, 1'b0); step();
        set_vc(2, 1'b1, 0, 1'b0);
        settle(); en("nw_b", 1'b1, 1, 1, 1'b0); step();
        set_vc(2, 1'b1, 0, 1'b1);
        settle(); en("nw_c", 1'b1, 2, 0, 1'b0); step();
        set_vc(2, 1'b0, 0, 1'b0);
        settle(); en("nw_d", 1'b1, 1, 1, 1'b0); step();
        grant_nw = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
